// File: rtl/seg7_mux_counter_if.sv
// rtl/seg7_mux_counter_if.sv - switch/mode inputs and display/count outputs of seg7_mux_counter
//
// Purpose: groups the non-clock signals of the counter/display block.
// Ports (as seen by the slave, i.e. the counter):
//   sw_i      in   raw push-switch level, 1 = pressed
//   up_i      in   count direction, 1 = increment
//   bcd_i     in   count mode, 1 = decimal, 0 = hexadecimal
//   seg_o     out  segment drive, bit0 = A .. bit6 = G
//   dig_en_o  out  one-hot active-high digit enable, bit 0 = least-significant digit
//   count_o   out  current count, nibble 0 = least-significant digit
interface seg7_mux_counter_if #(
   parameter int NUM_DIGITS = 2
);
   logic                    sw_i;
   logic                    up_i;
   logic                    bcd_i;
   logic [6:0]              seg_o;
   logic [NUM_DIGITS-1:0]   dig_en_o;
   logic [4*NUM_DIGITS-1:0] count_o;

   modport master (
      output sw_i, up_i, bcd_i,
      input  seg_o, dig_en_o, count_o
   );

   modport slave (
      input  sw_i, up_i, bcd_i,
      output seg_o, dig_en_o, count_o
   );
endinterface

// File: rtl/seg7_mux_counter.sv
// rtl/seg7_mux_counter.sv - debounced up/down hex/BCD counter with multiplexed 7-segment display
//
// Purpose: counts debounced switch presses and scans the count onto a
// multiplexed 7-segment display, one digit at a time.
// Ports:
//   clk_i   in  system clock, rising edge
//   rst_ni  in  asynchronous active-low reset
//   bus     slave modport of seg7_mux_counter_if (sw_i, up_i, bcd_i in;
//           seg_o, dig_en_o, count_o out)
module seg7_mux_counter #(
   parameter int NUM_DIGITS        = 2,
   parameter int CLKS_PER_DEBOUNCE = 250000,
   parameter int CLKS_PER_DIGIT    = 50000,
   parameter int ACTIVE_LOW_SEG    = 1,
   parameter int LZ_BLANK          = 0
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   seg7_mux_counter_if.slave bus
);

   localparam int DW = $clog2(CLKS_PER_DEBOUNCE);
   localparam int SW = $clog2(CLKS_PER_DIGIT);
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = 4 * NUM_DIGITS;
   localparam logic [DW-1:0] DB_LAST   = DW'(CLKS_PER_DEBOUNCE - 1);
   localparam logic [SW-1:0] SCAN_LAST = SW'(CLKS_PER_DIGIT - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
   localparam logic [6:0]    SEG_OFF   = (ACTIVE_LOW_SEG != 0) ? 7'h7F : 7'h00;

   logic [1:0]            sync_q;
   logic                  db_level_q;
   logic                  db_prev_q;
   logic [DW-1:0]         db_cnt_q;
   logic [CW-1:0]         count_q;
   logic [SW-1:0]         scan_cnt_q;
   logic [IW-1:0]         dig_idx_q;
   logic [6:0]            seg_q;
   logic [NUM_DIGITS-1:0] dig_en_q;

   logic                  step;
   logic [CW-1:0]         bcd_next;
   logic [CW-1:0]         count_next;
   logic                  carry;
   logic [3:0]            nib;
   logic [NUM_DIGITS-1:0] blank;
   logic                  zero_above;
   logic [3:0]            cur_nib;
   logic                  cur_blank;
   logic [6:0]            seg_raw;

   function automatic logic [6:0] decode(input logic [3:0] d);
      case (d)
         4'h0: decode = 7'h3F;
         4'h1: decode = 7'h06;
         4'h2: decode = 7'h5B;
         4'h3: decode = 7'h4F;
         4'h4: decode = 7'h66;
         4'h5: decode = 7'h6D;
         4'h6: decode = 7'h7D;
         4'h7: decode = 7'h07;
         4'h8: decode = 7'h7F;
         4'h9: decode = 7'h6F;
         4'hA: decode = 7'h77;
         4'hB: decode = 7'h7C;
         4'hC: decode = 7'h39;
         4'hD: decode = 7'h5E;
         4'hE: decode = 7'h79;
         default: decode = 7'h71;
      endcase
   endfunction

   // Synchronizer and debouncer. db_prev_q delays the debounced level so a
   // press is stepped on the edge after the debounced level rises.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sync_q     <= '0;
         db_level_q <= 1'b0;
         db_prev_q  <= 1'b0;
         db_cnt_q   <= '0;
      end else begin
         sync_q    <= {sync_q[0], bus.sw_i};
         db_prev_q <= db_level_q;
         if (sync_q[1] != db_level_q) begin
            if (db_cnt_q == DB_LAST) begin
               db_level_q <= sync_q[1];
               db_cnt_q   <= '0;
            end else begin
               db_cnt_q <= db_cnt_q + 1'b1;
            end
         end else begin
            db_cnt_q <= '0;
         end
      end
   end

   assign step = db_level_q & ~db_prev_q;

   // BCD ripple: carry/borrow enters at nibble 0 and stops at the first digit
   // that absorbs it; a non-decimal digit decrements straight to 9.
   always_comb begin
      bcd_next = count_q;
      carry    = 1'b1;
      nib      = '0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         nib = count_q[4*k +: 4];
         if (carry) begin
            if (bus.up_i) begin
               if (nib >= 4'd9) begin
                  bcd_next[4*k +: 4] = 4'd0;
               end else begin
                  bcd_next[4*k +: 4] = nib + 4'd1;
                  carry = 1'b0;
               end
            end else begin
               if (nib == 4'd0) begin
                  bcd_next[4*k +: 4] = 4'd9;
               end else if (nib > 4'd9) begin
                  bcd_next[4*k +: 4] = 4'd9;
                  carry = 1'b0;
               end else begin
                  bcd_next[4*k +: 4] = nib - 4'd1;
                  carry = 1'b0;
               end
            end
         end
      end
      if (bus.bcd_i) begin
         count_next = bcd_next;
      end else if (bus.up_i) begin
         count_next = count_q + 1'b1;
      end else begin
         count_next = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
      end else if (step) begin
         count_q <= count_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= '0;
      end else if (scan_cnt_q == SCAN_LAST) begin
         scan_cnt_q <= '0;
         dig_idx_q  <= (dig_idx_q == IDX_LAST) ? '0 : dig_idx_q + 1'b1;
      end else begin
         scan_cnt_q <= scan_cnt_q + 1'b1;
      end
   end

   // A digit above 0 is blanked when it and every digit above it are zero.
   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
         zero_above = zero_above & (count_q[4*k +: 4] == 4'd0);
         blank[k]   = (LZ_BLANK != 0) && zero_above;
      end
      cur_nib   = '0;
      cur_blank = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (dig_idx_q == IW'(k)) begin
            cur_nib   = count_q[4*k +: 4];
            cur_blank = blank[k];
         end
      end
      seg_raw = (ACTIVE_LOW_SEG != 0) ? ~decode(cur_nib) : decode(cur_nib);
   end

   // Enable and segments share one register stage so they switch together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         seg_q    <= SEG_OFF;
         dig_en_q <= '0;
      end else begin
         seg_q    <= cur_blank ? SEG_OFF : seg_raw;
         dig_en_q <= NUM_DIGITS'(1) << dig_idx_q;
      end
   end

   assign bus.seg_o    = seg_q;
   assign bus.dig_en_o = dig_en_q;
   assign bus.count_o  = count_q;

endmodule

// File: tb/tb_seg7_mux_counter.sv
// tb/tb_seg7_mux_counter.sv - directed self-checking bench for seg7_mux_counter
module tb_seg7_mux_counter;

   typedef struct {
      bit         up;
      bit         bcd;
      int         n;
      logic [7:0] exp;
      string      name;
   } vec_t;

   logic clk_i;
   logic rst_ni;
   int   checks;
   int   failures;
   int   guard;

   seg7_mux_counter_if #(.NUM_DIGITS(2)) bus0 ();
   seg7_mux_counter_if #(.NUM_DIGITS(2)) bus1 ();

   seg7_mux_counter #(
      .NUM_DIGITS(2), .CLKS_PER_DEBOUNCE(4), .CLKS_PER_DIGIT(8),
      .ACTIVE_LOW_SEG(1), .LZ_BLANK(0)
   ) dut0 (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus0)
   );

   seg7_mux_counter #(
      .NUM_DIGITS(2), .CLKS_PER_DEBOUNCE(4), .CLKS_PER_DIGIT(8),
      .ACTIVE_LOW_SEG(1), .LZ_BLANK(1)
   ) dut1 (
      .clk_i (clk_i),
      .rst_ni(rst_ni),
      .bus   (bus1)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic tick(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic press0(input int n);
      for (int i = 0; i < n; i++) begin
         bus0.sw_i = 1'b1;
         tick(10);
         bus0.sw_i = 1'b0;
         tick(10);
      end
   endtask

   task automatic press1(input int n);
      for (int i = 0; i < n; i++) begin
         bus1.sw_i = 1'b1;
         tick(10);
         bus1.sw_i = 1'b0;
         tick(10);
      end
   endtask

   task automatic do_reset();
      rst_ni = 1'b0;
      tick(2);
      rst_ni = 1'b1;
      tick(2);
   endtask

   vec_t tbl[16];

   initial begin
      checks   = 0;
      failures = 0;
      tbl[0]  = '{1'b1, 1'b0, 16, 8'h10, "hex_up16"};
      tbl[1]  = '{1'b0, 1'b0, 1,  8'h0F, "hex_dn_borrow"};
      tbl[2]  = '{1'b0, 1'b0, 15, 8'h00, "hex_dn15"};
      tbl[3]  = '{1'b0, 1'b0, 1,  8'hFF, "hex_dn_wrap"};
      tbl[4]  = '{1'b1, 1'b0, 1,  8'h00, "hex_up_wrap"};
      tbl[5]  = '{1'b1, 1'b1, 9,  8'h09, "bcd_up9"};
      tbl[6]  = '{1'b1, 1'b1, 1,  8'h10, "bcd_carry"};
      tbl[7]  = '{1'b1, 1'b1, 89, 8'h99, "bcd_up99"};
      tbl[8]  = '{1'b1, 1'b1, 1,  8'h00, "bcd_wrap"};
      tbl[9]  = '{1'b0, 1'b1, 1,  8'h99, "bcd_dn_wrap"};
      tbl[10] = '{1'b0, 1'b1, 9,  8'h90, "bcd_dn9"};
      tbl[11] = '{1'b0, 1'b1, 1,  8'h89, "bcd_borrow"};
      tbl[12] = '{1'b1, 1'b0, 6,  8'h8F, "hex_up6"};
      tbl[13] = '{1'b0, 1'b1, 1,  8'h89, "bcd_dn_gt9"};
      tbl[14] = '{1'b1, 1'b0, 6,  8'h8F, "hex_up6b"};
      tbl[15] = '{1'b1, 1'b1, 1,  8'h90, "bcd_up_gt9"};

      rst_ni     = 1'b1;
      bus0.sw_i  = 1'b0;
      bus0.up_i  = 1'b1;
      bus0.bcd_i = 1'b0;
      bus1.sw_i  = 1'b0;
      bus1.up_i  = 1'b1;
      bus1.bcd_i = 1'b0;
      tick(2);

      // Reset state, asserted between edges.
      rst_ni = 1'b0;
      #1;
      check("rst_count", 32'(bus0.count_o), 32'h00);
      check("rst_dig_en", 32'(bus0.dig_en_o), 32'h0);
      check("rst_seg", 32'(bus0.seg_o), 32'h7F);
      tick(2);
      rst_ni = 1'b1;
      #1;
      check("rel_dig_en_pre", 32'(bus0.dig_en_o), 32'h0);
      tick(1);
      check("rel_dig_en", 32'(bus0.dig_en_o), 32'h1);
      check("rel_seg", 32'(bus0.seg_o), 32'h40);

      // Bounce: 3-cycle pulses never reach the 4-cycle stability window.
      for (int i = 0; i < 10; i++) begin
         bus0.sw_i = 1'b1;
         tick(3);
         bus0.sw_i = 1'b0;
         tick(3);
      end
      tick(10);
      check("bounce_count", 32'(bus0.count_o), 32'h00);

      // Clean press: step lands on edge 7 counting from first sampling edge.
      bus0.sw_i = 1'b1;
      tick(6);
      check("press_edge6", 32'(bus0.count_o), 32'h00);
      tick(1);
      check("press_edge7", 32'(bus0.count_o), 32'h01);
      tick(3);
      bus0.sw_i = 1'b0;
      tick(15);
      check("release_no_step", 32'(bus0.count_o), 32'h01);

      // Mode/direction changes without a press leave the count alone.
      bus0.up_i  = 1'b0;
      bus0.bcd_i = 1'b1;
      tick(5);
      bus0.up_i  = 1'b1;
      bus0.bcd_i = 1'b0;
      tick(5);
      check("mode_toggle_hold", 32'(bus0.count_o), 32'h01);

      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus0.up_i  = tbl[i].up;
         bus0.bcd_i = tbl[i].bcd;
         press0(tbl[i].n);
         check(tbl[i].name, 32'(bus0.count_o), 32'(tbl[i].exp));
      end

      // Scan at 0x3A: digit 0 shows A, digit 1 shows 3.
      do_reset();
      bus0.up_i  = 1'b1;
      bus0.bcd_i = 1'b0;
      press0(58);
      check("scan_count", 32'(bus0.count_o), 32'h3A);
      guard = 0;
      while (bus0.dig_en_o != 2'b10 && guard < 40) begin
         tick(1);
         guard++;
      end
      while (bus0.dig_en_o != 2'b01 && guard < 40) begin
         tick(1);
         guard++;
      end
      check("scan_align", 32'(guard < 40), 32'h1);
      for (int i = 0; i < 32; i++) begin
         check("scan_dig_en", 32'(bus0.dig_en_o), ((i / 8) % 2 == 1) ? 32'h2 : 32'h1);
         check("scan_seg", 32'(bus0.seg_o), ((i / 8) % 2 == 1) ? 32'h30 : 32'h08);
         tick(1);
      end

      // Leading-zero blanking build at 0x05.
      bus1.up_i  = 1'b1;
      bus1.bcd_i = 1'b0;
      press1(5);
      check("lz_count", 32'(bus1.count_o), 32'h05);
      guard = 0;
      while (bus1.dig_en_o != 2'b10 && guard < 20) begin
         tick(1);
         guard++;
      end
      check("lz_align_hi", 32'(guard < 20), 32'h1);
      check("lz_seg_hi", 32'(bus1.seg_o), 32'h7F);
      guard = 0;
      while (bus1.dig_en_o != 2'b01 && guard < 20) begin
         tick(1);
         guard++;
      end
      check("lz_align_lo", 32'(guard < 20), 32'h1);
      check("lz_seg_lo", 32'(bus1.seg_o), 32'h12);

      // Reset during debounce discards the pending press.
      bus0.sw_i = 1'b1;
      tick(2);
      rst_ni = 1'b0;
      #1;
      check("mid_rst_async_count", 32'(bus0.count_o), 32'h00);
      tick(2);
      check("mid_rst_count", 32'(bus0.count_o), 32'h00);
      rst_ni = 1'b1;
      tick(2);
      bus0.sw_i = 1'b0;
      tick(20);
      check("mid_rst_no_step", 32'(bus0.count_o), 32'h00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_mux_counter.md
SEG7_MUX_COUNTER -- requirements
Module: seg7_mux_counter

Interface
REQ-001 Parameter NUM_DIGITS, default 2, number of displayed digits; legal range 1..4.
REQ-002 Parameter CLKS_PER_DEBOUNCE, default 250000, number of consecutive stable cycles required to accept a switch level; value must be at least 2.
REQ-003 Parameter CLKS_PER_DIGIT, default 50000, number of cycles each digit stays enabled during scanning; value must be at least 2.
REQ-004 Parameter ACTIVE_LOW_SEG, default 1, where 1 means segments are lit when the segment bit is 0.
REQ-005 Parameter LZ_BLANK, default 0, where 1 enables leading-zero blanking.
REQ-006 clk_i  input  1  single system clock; all logic uses its rising edge.
REQ-007 rst_ni  input  1  asynchronous active-low reset.
REQ-008 sw_i  input  1  raw, bouncing, asynchronous push-switch; 1 means pressed.
REQ-009 up_i  input  1  count direction; 1 means increment, 0 means decrement.
REQ-010 bcd_i  input  1  count mode; 1 means decimal (BCD), 0 means hexadecimal.
REQ-011 seg_o  output  7  segment drive, bit0=A through bit6=G, registered.
REQ-012 dig_en_o  output  NUM_DIGITS  one-hot, active-high digit enable, registered; bit 0 is the least-significant digit.
REQ-013 count_o  output  4*NUM_DIGITS  current count as nibbles; nibble 0 is the least-significant digit.

Function
REQ-014 sw_i shall pass through a 2-flop synchronizer before any other use.
REQ-015 Debounce: a counter shall increment each cycle that the synchronized level differs from the debounced level, and clear each cycle that they are equal.
REQ-016 On the CLKS_PER_DEBOUNCE-th consecutive differing cycle, the debounced level shall take the synchronized value and the debounce counter shall clear.
REQ-017 One count step shall occur on each debounced 0->1 transition only.
- A debounced 1->0 transition (release) shall not step the count.
- count_o shall update on the clock edge following the debounced transition.
REQ-018 up_i and bcd_i shall be sampled on the step cycle; changes to them between steps shall not alter count_o.
REQ-019 Hex mode: count_o shall be an unsigned binary value modulo 16^NUM_DIGITS.
- With NUM_DIGITS=2: up from 0xFF gives 0x00; down from 0x00 gives 0xFF.
REQ-020 BCD mode, per digit with ripple carry/borrow from nibble 0 upward:
- increment of a digit >=9 gives 0 and carries to the next digit;
- decrement of a digit 0 gives 9 and borrows from the next digit;
- decrement of a digit >9 gives 9 with no borrow;
- the top digit's carry/borrow out is discarded, so 99->00 up and 00->99 down.
REQ-021 Scan: a counter shall run 0..CLKS_PER_DIGIT-1 and wrap; at wrap, the digit index shall advance 0,1,..,NUM_DIGITS-1,0.
REQ-022 Each cycle, dig_en_o and seg_o shall be registered together from the current index and count_o, so they change on the same edge.
REQ-023 Decode (active-high, G..A) shall be: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- When ACTIVE_LOW_SEG=1, seg_o shall be the bitwise inverse of this value.
REQ-024 When LZ_BLANK=1, a digit other than digit 0 shall show all segments off if it and every more-significant digit are 0.
REQ-025 Single-digit build (NUM_DIGITS=1): dig_en_o shall be constant 1 after reset.

Reset
REQ-026 While rst_ni=0 (asynchronous assertion), the following shall hold:
- count_o=0, dig_en_o=0;
- seg_o=all segments off (7'h7F if ACTIVE_LOW_SEG=1, else 7'h00);
- synchronizer, debounced level, debounce counter, scan counter and digit index all 0.
REQ-027 On the first edge after rst_ni rises, dig_en_o shall be 1 and seg_o shall show the decode of nibble 0.
REQ-028 Reset asserted mid-debounce shall discard the pending transition; no step shall occur because of it.

Verification (NUM_DIGITS=2, CLKS_PER_DEBOUNCE=4, CLKS_PER_DIGIT=8, ACTIVE_LOW_SEG=1, LZ_BLANK=0)
REQ-029 Reset pulse -> count_o=0x00, dig_en_o=00, seg_o=7F; one edge after release -> dig_en_o=01, seg_o=40.
REQ-030 sw_i high 3 cycles then low, repeated 10 times -> count_o stays 0x00; clean press held 10 cycles -> count_o=0x01 exactly 2+4+1 edges after the press is first sampled; release -> no change.
REQ-031 Hex mode, up, 16 presses from 0x00 -> count_o=0x10; one down press -> 0x0F; down press from 0x00 -> 0xFF.
REQ-032 BCD mode, up, 100 presses from 0x00 -> count_o=0x00, passing through 0x09->0x10 and 0x99->0x00; down press from 0x00 -> 0x99.
REQ-033 count_o=0x3A with scan running -> dig_en_o alternates 01/10 every 8 cycles, with seg_o=08 for the 01 phase and seg_o=30 for the 10 phase; rebuild with LZ_BLANK=1 and count 0x05 -> seg_o=7F during the 10 phase.
REQ-034 rst_ni pulsed low 2 cycles after a press begins debouncing -> count_o=0x00 and no step after release, even with sw_i still held.
